// File: rtl/stp_pkg.sv
// Shared constants for the STM32-to-MRAM serial receiver.
// Default word width is shared with the MRAM controller.
package stp_pkg;

    localparam int unsigned STP_DEFAULT_BUS_WIDTH = 8;

    // Counter must be able to represent 0..bus_width.
    function automatic int unsigned stp_cnt_w(input int unsigned bus_width);
        return $clog2(bus_width + 1);
    endfunction

endpackage

// File: rtl/stp_shift_core.sv
// Serial shift register and bit counter; flags word_done on the final bit.
// Bit order selected by STP_MSB_FIRST_EN (defined: MSB-first, undefined: LSB-first).
module stp_shift_core
    import stp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = STP_DEFAULT_BUS_WIDTH,
    parameter int unsigned CNT_W     = stp_cnt_w(BUS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 data_in,
    input  logic                 frame_clr,
    output logic                 word_done,
    output logic [BUS_WIDTH-1:0] word,
    output logic                 busy
);

    logic [BUS_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic [BUS_WIDTH-1:0] shreg_next;

    always_comb begin
`ifdef STP_MSB_FIRST_EN
        shreg_next = {shreg[BUS_WIDTH-2:0], data_in};
`else
        shreg_next = {data_in, shreg[BUS_WIDTH-1:1]};
`endif
    end

    // frame_clr discards the bit in the same cycle, even a completion bit.
    assign word_done = en & ~frame_clr & (cnt == CNT_W'(BUS_WIDTH - 1));
    assign word      = shreg_next;
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (frame_clr) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (en) begin
            shreg <= shreg_next;
            cnt   <= word_done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stp_deserializer.sv
// Serial-to-parallel receiver with valid/ready holding register and sticky overrun.
// Bit order is chosen inside stp_shift_core via STP_MSB_FIRST_EN.
module stp_deserializer
    import stp_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = STP_DEFAULT_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 data_in,
    input  logic                 frame_clr,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned CNT_W = stp_cnt_w(BUS_WIDTH);

    logic                 word_done;
    logic [BUS_WIDTH-1:0] word;

    stp_shift_core #(
        .BUS_WIDTH (BUS_WIDTH),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .frame_clr (frame_clr),
        .word_done (word_done),
        .word      (word),
        .busy      (busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done) begin
                // A consumer taking the old word this cycle frees the slot.
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (frame_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stp_deserializer.sv
// Directed bench for stp_deserializer (BUS_WIDTH=8); expectations follow STP_MSB_FIRST_EN.
module tb_stp_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       data_in;
    logic       frame_clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;

    int unsigned total = 0;
    int unsigned bad   = 0;

    stp_deserializer #(.BUS_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .frame_clr (frame_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // seq[i] is the i-th bit on the wire; exp_lsb/exp_msb are hand-computed results.
    typedef struct {
        logic [7:0]  seq;
        int unsigned gap;
        logic [7:0]  exp_lsb;
        logic [7:0]  exp_msb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [7:0] seq);
        logic [7:0] r;
`ifdef STP_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = seq[i];
`else
        r = seq;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        en      = 1'b1;
        data_in = b;
        tick();
        en      = 1'b0;
        data_in = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seq, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_bit(seq[i]);
    endtask

    initial begin
        vecs[0] = '{seq: 8'h4D, gap: 0, exp_lsb: 8'h4D, exp_msb: 8'hB2};
        vecs[1] = '{seq: 8'hA5, gap: 1, exp_lsb: 8'hA5, exp_msb: 8'hA5};
        vecs[2] = '{seq: 8'h01, gap: 0, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[3] = '{seq: 8'hF0, gap: 3, exp_lsb: 8'hF0, exp_msb: 8'h0F};
        vecs[4] = '{seq: 8'h3C, gap: 2, exp_lsb: 8'h3C, exp_msb: 8'h3C};
        vecs[5] = '{seq: 8'hFF, gap: 0, exp_lsb: 8'hFF, exp_msb: 8'hFF};

        rst = 1'b1; en = 1'b0; data_in = 1'b0; frame_clr = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("reset out_data", out_data, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Table-driven single words, consumer always ready.
        for (int unsigned v = 0; v < 6; v++) begin
            logic [7:0] e;
`ifdef STP_MSB_FIRST_EN
            e = vecs[v].exp_msb;
`else
            e = vecs[v].exp_lsb;
`endif
            for (int unsigned i = 0; i < 8; i++) begin
                send_bit(vecs[v].seq[i]);
                if (i == 0) chk("vec busy after first bit", busy, 1);
                if (i == 6) chk("vec no early valid", out_valid, 0);
                if (i != 7) repeat (vecs[v].gap) tick();
            end
            chk("vec out_valid", out_valid, 1);
            chk("vec out_data", out_data, e);
            chk("vec busy done", busy, 0);
            tick();
            chk("vec valid one cycle", out_valid, 0);
            chk("vec data held", out_data, e);
        end

        // Overrun: holding register full, second word dropped.
        out_ready = 1'b0;
        send_seq(8'h4D, 8);
        chk("ovr first valid", out_valid, 1);
        chk("ovr first data", out_data, exp_of(8'h4D));
        chk("ovr none yet", overrun, 0);
        send_seq(8'hFF, 8);
        chk("ovr data kept", out_data, exp_of(8'h4D));
        chk("ovr valid kept", out_valid, 1);
        chk("ovr flagged", overrun, 1);
        out_ready = 1'b1;
        tick();
        chk("ovr valid drop", out_valid, 0);
        chk("ovr sticky", overrun, 1);
        tick();
        chk("ovr still sticky", overrun, 1);
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0;
        chk("ovr cleared", overrun, 0);

        // Back-to-back: ready rises exactly on the completion cycle of word 2.
        out_ready = 1'b0;
        send_seq(8'h4D, 8);
        chk("b2b first data", out_data, exp_of(8'h4D));
        for (int unsigned i = 0; i < 7; i++) begin
            send_bit(vecs[1].seq[i]);
            chk("b2b valid held", out_valid, 1);
        end
        out_ready = 1'b1;
        send_bit(vecs[1].seq[7]);
        chk("b2b valid cont", out_valid, 1);
        chk("b2b new data", out_data, exp_of(8'hA5));
        chk("b2b no overrun", overrun, 0);
        tick();
        chk("b2b consumed", out_valid, 0);

        // Abort with frame_clr coinciding with en.
        send_seq(8'h1F, 5);
        chk("abort busy before", busy, 1);
        en = 1'b1; data_in = 1'b1; frame_clr = 1'b1;
        tick();
        en = 1'b0; data_in = 1'b0; frame_clr = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort no valid", out_valid, 0);
        send_seq(8'h3C, 7);
        chk("abort no early word", out_valid, 0);
        send_bit(1'b0);
        chk("abort clean valid", out_valid, 1);
        chk("abort clean data", out_data, exp_of(8'h3C));
        tick();

        // Abort landing on what would have been the completion bit.
        send_seq(8'h7F, 7);
        en = 1'b1; data_in = 1'b1; frame_clr = 1'b1;
        tick();
        en = 1'b0; data_in = 1'b0; frame_clr = 1'b0;
        chk("abort final bit no valid", out_valid, 0);
        chk("abort final bit busy", busy, 0);

        // Asynchronous reset mid-word while a word is held.
        out_ready = 1'b0;
        send_seq(8'hA5, 8);
        send_seq(8'h07, 3);
        chk("rst pre valid", out_valid, 1);
        chk("rst pre busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst data", out_data, 0);
        chk("async rst valid", out_valid, 0);
        chk("async rst busy", busy, 0);
        chk("async rst overrun", overrun, 0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send_seq(8'h01, 8);
        chk("post rst valid", out_valid, 1);
        chk("post rst data", out_data, exp_of(8'h01));
        chk("post rst overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stp_deserializer.md
Name: stp_deserializer

Overview:
Parametrised serial-to-parallel receiver for the STM32-to-MRAM bridge. It samples one serial bit per enabled clock into a shift register and counts bits. When BUS_WIDTH bits have arrived, it transfers the completed word to a holding register. The word is presented with a valid/ready handshake, together with frame-abort and overrun reporting, so downstream MRAM control logic only ever sees complete, stable words.

Parameters:
BUS_WIDTH, 8, number of serial bits per parallel word; legal range 2..64.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  shift strobe; data_in is sampled on every clk edge where en=1
data_in  input  1  serial data bit
frame_clr  input  1  synchronous abort: discards the partial word and clears overrun
out_data  output  BUS_WIDTH  last completed word (holding register)
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1
busy  output  1  partial word in progress (bit count != 0)
overrun  output  1  sticky: a completed word was dropped because the holding register was full

Behaviour:
- Reset (async, rst=1): shift register=0, bit counter=0, out_data=0, out_valid=0, busy=0, overrun=0.
- Shift, default LSB-first: on en=1, shreg <= {data_in, shreg[BUS_WIDTH-1:1]}. The first received bit ends in bit 0.
- Bit counter width is CNT_W=$clog2(BUS_WIDTH+1). It increments on each en=1. busy = (cnt != 0).
- Completion: the en cycle with cnt==BUS_WIDTH-1 is the completion cycle. In that cycle the counter wraps to 0, and the completed word {data_in, shreg[BUS_WIDTH-1:1]} is offered to the holding register. Shreg is not cleared; the next word overwrites it.
- Latency: out_data and out_valid update on the same edge that samples the final bit. Both are visible one cycle after the last en is presented.
- Handshake: a transfer occurs when out_valid & out_ready. Without a new completion, out_valid goes 0 next cycle and out_data holds its value. out_data is stable while out_valid=1.
- Completion with the holding register free (out_valid=0) loads the word and sets out_valid=1.
- Completion with out_valid=1 and out_ready=1 in the same cycle loads the new word, and out_valid stays 1. No gap, no overrun.
- Completion with out_valid=1 and out_ready=0 drops the new word. out_data keeps the old word and overrun is set to 1, staying set until frame_clr or rst.
- en=0: shreg, counter and busy hold. Gaps between bits of any length are legal.
- frame_clr=1: shreg=0, cnt=0 and overrun=0 next edge. out_data and out_valid are unaffected, and the handshake still completes that cycle.
- frame_clr=1 together with en=1: frame_clr wins and the bit is discarded, including when that bit would have been the completion bit.
- rst asserted mid-word or mid-handshake: everything returns to reset values immediately. The pending word is lost and no overrun is flagged.
- Single-process state: no FSM beyond the counter and the valid flag (logical states: EMPTY/FULL x counter).

Optional Feature:
Macro STP_MSB_FIRST_EN.
- Defined: shift left, shreg <= {shreg[BUS_WIDTH-2:0], data_in}. The first bit lands in bit BUS_WIDTH-1, and the completed word is {shreg[BUS_WIDTH-2:0], data_in}.
- Undefined: LSB-first as above.
- All counting, handshake and overrun behaviour is identical in both builds.

Decomposition:
- Package stp_pkg: function/constant for CNT_W derivation, and a localparam for the default BUS_WIDTH shared with the MRAM controller.
- Sub-module stp_shift_core: holds the shift register, bit counter and the bit-order macro. It outputs word_done and word.
- The top, stp_deserializer, holds the holding register, handshake and overrun logic.

Test Plan:
1. BUS_WIDTH=8, LSB-first, out_ready=1: send 1,0,1,1,0,0,1,0 with en=1 every cycle. Expect out_data=0x4D and out_valid=1 for exactly 1 cycle, one cycle after the 8th bit; busy=0 afterwards.
2. Same stream built with STP_MSB_FIRST_EN: expect out_data=0xB2 with identical timing.
3. out_ready=0: send 0x4D, then 0xFF. Expect out_data=0x4D held, out_valid=1, and overrun=1 after the 16th bit. Raise out_ready: out_valid drops and overrun stays 1. Pulse frame_clr: overrun=0.
4. Back-to-back words with out_ready asserted exactly on the completion cycle of the 2nd word. Expect out_valid to remain 1 continuously, out_data to change 0x4D->0xA5, and overrun=0.
5. Send 5 bits, then pulse frame_clr with en=1. Expect busy=0 and the bit discarded. The next 8 bits form 0x3C exactly, with no stale bits from the aborted word.
6. Assert rst after 3 bits while out_valid=1. Expect all outputs 0 immediately, asynchronously before the next clk edge. After release, a clean 8-bit frame yields the correct word.
